// File: rtl/instr_entry_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_entry_queue                                            |
// | Description : Captures one 16-bit instruction word {codop, addA, addB_LMM, |
// |               addC} per debounced press of the "enter" pushbutton into a   |
// |               small FIFO. The FIFO head goes to the CPU fetch/decode stage |
// |               over a valid/ready handshake. The block also reports         |
// |               occupancy and a sticky overflow flag.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk          in   1   system clock, all logic on posedge                 |
// |   rst_n        in   1   asynchronous active-low reset                      |
// |   KEY          in   4   pushbuttons, active-low                            |
// |                         [0] enter, [1] clear overflow, [3:2] unused        |
// |   codop        in   4   opcode field                                       |
// |   addA         in   4   register A address                                 |
// |   addB_LMM     in   4   register B address or immediate                    |
// |   addC         in   4   destination address                                |
// |   instr_ready  in   1   CPU accepts the head word this cycle               |
// |   instr_valid  out  1   FIFO non-empty, head word valid                    |
// |   instr_data   out  16  head word                                          |
// |   count        out  $clog2(DEPTH+1)  current occupancy                     |
// |   full         out  1   count == DEPTH                                     |
// |   overflow     out  1   sticky: a press was dropped while full             |
// |   last_entered out  16  most recently accepted word                        |
// |                         (only with INSTR_ENTRY_ECHO_EN)                    |
// +----------------------------------------------------------------------------+
// | Optional build macro                                                       |
// |   INSTR_ENTRY_ECHO_EN : adds the last_entered echo port and its register.  |
// +----------------------------------------------------------------------------+
module instr_entry_queue #(
   parameter int DEPTH           = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [3:0]                 KEY,
   input  logic [3:0]                 codop,
   input  logic [3:0]                 addA,
   input  logic [3:0]                 addB_LMM,
   input  logic [3:0]                 addC,
   input  logic                       instr_ready,
   output logic                       instr_valid,
   output logic [15:0]                instr_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       overflow
`ifdef INSTR_ENTRY_ECHO_EN
   ,
   output logic [15:0]                last_entered
`endif
);

   // ------------------------------------------------------------------------
   // Derived constants
   // ------------------------------------------------------------------------
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = $clog2(DEPTH + 1);

   localparam logic [OCC_W-1:0] C_DEPTH   = OCC_W'(DEPTH);
   localparam logic [OCC_W-1:0] C_OCC_ONE = OCC_W'(1);
   localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] C_DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_DB_ONE  = CNT_W'(1);

   // ------------------------------------------------------------------------
   // Debounce state encoding
   // ------------------------------------------------------------------------
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ARM_PRESS = 2'd1,
      PRESSED   = 2'd2,
      ARM_REL   = 2'd3
   } db_state_t;

   // ------------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------------
   logic [1:0]       key_meta_q;
   logic [1:0]       key_sync_q;
   logic             key0_sync;
   logic             key1_sync;

   db_state_t        db_state_q, db_state_d;
   logic [CNT_W-1:0] db_cnt_q,   db_cnt_d;
   logic             push;

   logic [15:0]      mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0] count_q,  count_d;
   logic             overflow_q, overflow_d;

   logic [15:0]      entry_word;
   logic             is_empty;
   logic             is_full;
   logic             pop;
   logic             push_accept;
   logic             push_drop;

   // KEY[3:2] have no function in this block.
   logic             unused_keys;
   assign unused_keys = &KEY[3:2];

   // ------------------------------------------------------------------------
   // Two-flop synchronizers for KEY[1:0]. They reset to 1 because the keys
   // are active-low, so reset looks like "released".
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_meta_q <= 2'b11;
         key_sync_q <= 2'b11;
      end else begin
         key_meta_q <= KEY[1:0];
         key_sync_q <= key_meta_q;
      end
   end

   assign key0_sync = key_sync_q[0];
   assign key1_sync = key_sync_q[1];

   // ------------------------------------------------------------------------
   // Debounce FSM for the enter key. One counter serves both the press and
   // the release qualification. The push pulse fires only on the
   // ARM_PRESS -> PRESSED transition, so a long hold still gives one word.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_state_q <= IDLE;
         db_cnt_q   <= '0;
      end else begin
         db_state_q <= db_state_d;
         db_cnt_q   <= db_cnt_d;
      end
   end

   always_comb begin
      db_state_d = db_state_q;
      db_cnt_d   = db_cnt_q;
      push       = 1'b0;
      unique case (db_state_q)
         IDLE: begin
            if (!key0_sync) begin
               db_state_d = ARM_PRESS;
               db_cnt_d   = '0;
            end
         end
         ARM_PRESS: begin
            if (key0_sync) begin
               db_state_d = IDLE;
            end else if (db_cnt_q == C_DB_LAST) begin
               db_state_d = PRESSED;
               push       = 1'b1;
            end else begin
               db_cnt_d = db_cnt_q + C_DB_ONE;
            end
         end
         PRESSED: begin
            if (key0_sync) begin
               db_state_d = ARM_REL;
               db_cnt_d   = '0;
            end
         end
         ARM_REL: begin
            if (!key0_sync) begin
               db_state_d = PRESSED;
            end else if (db_cnt_q == C_DB_LAST) begin
               db_state_d = IDLE;
            end else begin
               db_cnt_d = db_cnt_q + C_DB_ONE;
            end
         end
         default: begin
            db_state_d = IDLE;
            db_cnt_d   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // FIFO control
   // ------------------------------------------------------------------------
   assign entry_word = {codop, addA, addB_LMM, addC};
   assign is_empty   = (count_q == '0);
   assign is_full    = (count_q == C_DEPTH);

   // instr_ready is ignored while empty, and a push never bypasses to the head.
   assign pop         = !is_empty && instr_ready;
   // When full, a push is accepted only if the head is leaving this cycle.
   assign push_accept = push && (!is_full || pop);
   assign push_drop   = push && is_full && !pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_accept) begin
         wr_ptr_d = wr_ptr_q + C_PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + C_PTR_ONE;
      end
      unique case ({push_accept, pop})
         2'b10:   count_d = count_q + C_OCC_ONE;
         2'b01:   count_d = count_q - C_OCC_ONE;
         default: count_d = count_q;
      endcase
   end

   // A set event wins over a clear request in the same cycle.
   always_comb begin
      overflow_d = overflow_q;
      if (push_drop) begin
         overflow_d = 1'b1;
      end else if (!key1_sync) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage. When the FIFO is full and pops and pushes in the same cycle,
   // wr_ptr equals rd_ptr. The old head is read combinationally before the
   // edge overwrites it, so both transfers are safe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push_accept) begin
         mem_q[wr_ptr_q] <= entry_word;
      end
   end

`ifdef INSTR_ENTRY_ECHO_EN
   // ------------------------------------------------------------------------
   // Operator echo: follows accepted pushes only.
   // ------------------------------------------------------------------------
   logic [15:0] last_entered_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_entered_q <= '0;
      end else if (push_accept) begin
         last_entered_q <= entry_word;
      end
   end

   assign last_entered = last_entered_q;
`endif

   // ------------------------------------------------------------------------
   // Outputs. The head is forced to zero while empty, so stale entries left
   // behind by earlier pops are never presented.
   // ------------------------------------------------------------------------
   assign instr_valid = !is_empty;
   assign instr_data  = is_empty ? 16'h0000 : mem_q[rd_ptr_q];
   assign count       = count_q;
   assign full        = is_full;
   assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_entry_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instr_entry_queue                                         |
// | Description : Directed self-checking bench for instr_entry_queue, built   |
// |               with DEPTH = 4 and DEBOUNCE_CYCLES = 8.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_instr_entry_queue;

   localparam int DEPTH           = 4;
   localparam int DEBOUNCE_CYCLES = 8;

   logic        clk;
   logic        rst_n;
   logic [3:0]  KEY;
   logic [3:0]  codop;
   logic [3:0]  addA;
   logic [3:0]  addB_LMM;
   logic [3:0]  addC;
   logic        instr_ready;
   logic        instr_valid;
   logic [15:0] instr_data;
   logic [2:0]  count;
   logic        full;
   logic        overflow;
`ifdef INSTR_ENTRY_ECHO_EN
   logic [15:0] last_entered;
`endif

   int n_cmp;
   int n_fail;

   instr_entry_queue #(
      .DEPTH           (DEPTH),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .KEY          (KEY),
      .codop        (codop),
      .addA         (addA),
      .addB_LMM     (addB_LMM),
      .addC         (addC),
      .instr_ready  (instr_ready),
      .instr_valid  (instr_valid),
      .instr_data   (instr_data),
      .count        (count),
      .full         (full),
      .overflow     (overflow)
`ifdef INSTR_ENTRY_ECHO_EN
      ,
      .last_entered (last_entered)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_word(input logic [15:0] w);
      {codop, addA, addB_LMM, addC} = w;
   endtask

   // One clean press: held long enough to debounce, then released long
   // enough for the FSM to return to IDLE.
   task automatic press(input logic [15:0] w);
      set_word(w);
      KEY[0] = 1'b0;
      step(14);
      KEY[0] = 1'b1;
      step(14);
   endtask

   initial begin
      n_cmp       = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      KEY         = 4'hF;
      instr_ready = 1'b0;
      set_word(16'h0000);

      // ---------------- reset state ----------------
      step(2);
      chk("rst_valid", 32'(instr_valid), 32'h0);
      chk("rst_data",  32'(instr_data),  32'h0);
      chk("rst_count", 32'(count),       32'h0);
      chk("rst_full",  32'(full),        32'h0);
      chk("rst_ovf",   32'(overflow),    32'h0);
`ifdef INSTR_ENTRY_ECHO_EN
      chk("rst_echo",  32'(last_entered), 32'h0);
`endif
      rst_n = 1'b1;
      step(2);

      // ---------------- 1: single press, latency ----------------
      set_word(16'h1234);
      KEY[0] = 1'b0;
      step(10);
      chk("s1_valid_early", 32'(instr_valid), 32'h0);
      step(1);
      chk("s1_valid", 32'(instr_valid), 32'h1);
      chk("s1_data",  32'(instr_data),  32'h1234);
      chk("s1_count", 32'(count),       32'h1);
      step(9);
      KEY[0] = 1'b1;
      step(20);
      chk("s1_one_push", 32'(count), 32'h1);
      instr_ready = 1'b1;
      step(1);
      instr_ready = 1'b0;
      chk("s1_drain_valid", 32'(instr_valid), 32'h0);
      chk("s1_drain_data",  32'(instr_data),  32'h0);

      // ---------------- 2: bounce rejection ----------------
      for (int i = 0; i < 10; i++) begin
         KEY[0] = ~KEY[0];
         step(3);
      end
      KEY[0] = 1'b1;
      step(20);
      chk("s2_count", 32'(count), 32'h0);
      chk("s2_valid", 32'(instr_valid), 32'h0);

      // ---------------- 3: fill and overflow ----------------
      for (int i = 1; i <= 4; i++) begin
         press(16'hA000 | 16'(i));
      end
      chk("s3_count4", 32'(count),    32'h4);
      chk("s3_full4",  32'(full),     32'h1);
      chk("s3_ovf4",   32'(overflow), 32'h0);
      press(16'hA005);
      chk("s3_count5", 32'(count),      32'h4);
      chk("s3_full5",  32'(full),       32'h1);
      chk("s3_ovf5",   32'(overflow),   32'h1);
      chk("s3_head",   32'(instr_data), 32'hA001);
`ifdef INSTR_ENTRY_ECHO_EN
      chk("s3_echo",   32'(last_entered), 32'hA004);
`endif

      // ---------------- 4: drain, then clear overflow ----------------
      instr_ready = 1'b1;
      chk("s4_pop1", 32'(instr_data), 32'hA001);
      step(1);
      chk("s4_pop2", 32'(instr_data), 32'hA002);
      step(1);
      chk("s4_pop3", 32'(instr_data), 32'hA003);
      step(1);
      chk("s4_pop4", 32'(instr_data), 32'hA004);
      step(1);
      chk("s4_valid", 32'(instr_valid), 32'h0);
      chk("s4_count", 32'(count),       32'h0);
      chk("s4_ovf_sticky", 32'(overflow), 32'h1);
      instr_ready = 1'b0;
      step(3);
      chk("s4_ovf_hold", 32'(overflow), 32'h1);
      KEY[1] = 1'b0;
      step(4);
      KEY[1] = 1'b1;
      step(3);
      chk("s4_ovf_clr", 32'(overflow), 32'h0);

      // ---------------- 5: push and pop together while full ----------------
      for (int i = 1; i <= 4; i++) begin
         press(16'hC000 | 16'(i));
      end
      chk("s5_full", 32'(full), 32'h1);
      set_word(16'hBEEF);
      KEY[0] = 1'b0;
      step(10);
      chk("s5_pre_count", 32'(count), 32'h4);
      instr_ready = 1'b1;
      step(1);
      instr_ready = 1'b0;
      chk("s5_count", 32'(count),      32'h4);
      chk("s5_ovf",   32'(overflow),   32'h0);
      chk("s5_head",  32'(instr_data), 32'hC002);
      step(3);
      KEY[0] = 1'b1;
      step(14);
`ifdef INSTR_ENTRY_ECHO_EN
      chk("s5_echo", 32'(last_entered), 32'hBEEF);
`endif
      instr_ready = 1'b1;
      chk("s5_pop1", 32'(instr_data), 32'hC002);
      step(1);
      chk("s5_pop2", 32'(instr_data), 32'hC003);
      step(1);
      chk("s5_pop3", 32'(instr_data), 32'hC004);
      step(1);
      chk("s5_pop4", 32'(instr_data), 32'hBEEF);
      step(1);
      chk("s5_empty", 32'(instr_valid), 32'h0);
      instr_ready = 1'b0;

      // ---------------- 6: reset mid-debounce ----------------
      press(16'hD001);
      press(16'hD002);
      chk("s6_pre_count", 32'(count), 32'h2);
      set_word(16'hE00E);
      KEY[0] = 1'b0;
      step(5);
      rst_n = 1'b0;
      #1;
      chk("s6_count", 32'(count),       32'h0);
      chk("s6_valid", 32'(instr_valid), 32'h0);
      chk("s6_ovf",   32'(overflow),    32'h0);
`ifdef INSTR_ENTRY_ECHO_EN
      chk("s6_echo",  32'(last_entered), 32'h0);
`endif
      step(2);
      rst_n = 1'b1;
      step(10);
      chk("s6_no_early_push", 32'(count), 32'h0);
      step(1);
      chk("s6_new_push", 32'(count),      32'h1);
      chk("s6_new_data", 32'(instr_data), 32'hE00E);
      KEY[0] = 1'b1;
      step(14);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instr_entry_queue.md
Name: instr_entry_queue

Overview:
- Downstream consumer of the switch-field reader outputs (codop, addA, addB_LMM, addC).
- Each debounced press of the "enter" pushbutton captures one 16-bit instruction word into a small FIFO.
- Presents the FIFO head to the CPU fetch/decode stage over a valid/ready handshake.
- Decouples slow human entry from CPU consumption; reports queue occupancy and overflow.

Parameters:
- DEPTH, 4: FIFO entries. Power of two, at least 2.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz). Benches override to 8.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): debounce counter width. Derived; do not override.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- KEY  in  4  pushbuttons, active-low. KEY[0] = enter; KEY[1] = clear overflow; KEY[3:2] unused.
- codop  in  4  opcode field.
- addA  in  4  register A address.
- addB_LMM  in  4  register B address or immediate.
- addC  in  4  destination address.
- instr_ready  in  1  CPU accepts the head word this cycle.
- instr_valid  out  1  FIFO non-empty; head word is valid.
- instr_data  out  16  head word {codop, addA, addB_LMM, addC}.
- count  out  $clog2(DEPTH+1)  current occupancy.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky flag: a press was dropped because the FIFO was full.

Behaviour:
- Reset, asynchronous on rst_n low:
  - FIFO emptied, pointers = 0.
  - Debounce FSM to IDLE, counter = 0, synchronizer flops = 1 (released).
  - Outputs: instr_valid = 0, instr_data = 0, count = 0, full = 0, overflow = 0.
  - Reset mid-operation discards all queued words and any partially debounced press.
- Synchronizer: KEY[0] and KEY[1] each pass through a 2-flop synchronizer before any other use.
- Debounce FSM for KEY[0], one counter:
  - IDLE: sync level 1. Sync 0 -> ARM_PRESS, counter cleared.
  - ARM_PRESS: counter increments while sync = 0. Sync 1 -> IDLE. Counter reaches DEBOUNCE_CYCLES-1 -> PRESSED, with a one-cycle push pulse.
  - PRESSED: sync 1 -> ARM_REL, counter cleared.
  - ARM_REL: counter increments while sync = 1. Sync 0 -> PRESSED. Counter reaches DEBOUNCE_CYCLES-1 -> IDLE.
  - Exactly one push per physical press, whatever the hold time. Bounces shorter than DEBOUNCE_CYCLES produce no push.
- Capture: on the push cycle, the word {codop, addA, addB_LMM, addC} sampled that cycle is written at the write pointer.
- Pop: when instr_valid && instr_ready, the read pointer advances. instr_data is combinational from the head entry.
- Latency: push cycle -> instr_valid high on the next clock edge when the FIFO was empty. Physical press -> push = 2 + DEBOUNCE_CYCLES cycles.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count tracks occupancy.
- Full:
  - A push while full and no pop in the same cycle is dropped; overflow is set, count is unchanged.
  - A push and a pop in the same cycle while full are both accepted; count is unchanged, overflow is not set.
- Empty: instr_ready is ignored. A push while empty does not bypass; the word becomes visible the next cycle.
- overflow clears only on reset, or on a synchronized KEY[1] low level (no debounce needed). If a clear and an overflow event occur in the same cycle, set wins.
- instr_data is held stable while instr_valid && !instr_ready.

Optional Feature:
- Macro: INSTR_ENTRY_ECHO_EN.
- Defined:
  - Extra output port last_entered out 16 holds the most recently accepted word (reset 0). It updates only on accepted pushes, not on dropped ones.
  - Used to drive HEX displays for operator confirmation.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan (DEBOUNCE_CYCLES = 8, DEPTH = 4):
1. Switch fields 0x1, 0x2, 0x3, 0x4; KEY[0] held low 20 cycles, then high 20 cycles; instr_ready = 0.
   - Exactly one push.
   - instr_valid = 1, instr_data = 0x1234, count = 1, 1 + (2 + 8) cycles after the falling edge.
2. KEY[0] toggled low/high every 3 cycles for 30 cycles, then held high.
   - No push; count stays 0.
3. Five debounced presses with words 0xA001 through 0xA005; instr_ready = 0.
   - count = 4, full = 1, overflow = 1 after the fifth press.
   - Head remains 0xA001.
4. From the full state of scenario 3, hold instr_ready = 1.
   - Pops return 0xA001, 0xA002, 0xA003, 0xA004 on consecutive cycles.
   - Then instr_valid = 0, count = 0; overflow stays 1 until KEY[1] is pulsed low, then reads 0.
5. Full FIFO with instr_ready = 1 on the same cycle as a push of 0xBEEF.
   - count stays 4, overflow = 0.
   - 0xBEEF is popped fourth after the current head.
6. rst_n asserted low mid-debounce with 2 entries queued.
   - Immediately: count = 0, instr_valid = 0, overflow = 0.
   - No push appears after release until a new full debounce completes.
   - With INSTR_ENTRY_ECHO_EN defined, last_entered = 0.
